// File: rtl/mips_core.sv
// Multi-cycle (5 clocks/instruction) 32-bit MIPS integer core with external icache, dcache and register file.
// Optional branch/jump support (BEQ, BNE, J) is enabled by defining MIPS_CORE_BRANCH_EN.
module mips_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iCacheReadData,
    output logic [31:0] iCacheReadAddr,
    input  logic [31:0] dCacheReadData,
    output logic [31:0] dCacheWriteData,
    output logic [31:0] dCacheAddr,
    output logic        dCacheWriteEn,
    output logic        dCacheReadEn,
    input  logic [31:0] rfReadData_p0,
    output logic [4:0]  rfReadAddr_p0,
    output logic        rfReadEn_p0,
    input  logic [31:0] rfReadData_p1,
    output logic [4:0]  rfReadAddr_p1,
    output logic        rfReadEn_p1,
    output logic [31:0] rfWriteData_p0,
    output logic [4:0]  rfWriteAddr_p0,
    output logic        rfWriteEn_p0
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] st_q, st_d;
    logic [31:0] npc_q, npc_d;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, dest;
    logic [31:0] imm_sext, imm_zext, pc_plus4;
    logic [31:0] alu_res;
    logic        reg_write, is_load, is_store;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_zext = {16'h0000, ir_q[15:0]};
    assign pc_plus4 = pc_q + 32'd4;
    assign dest     = (op == OP_RTYPE) ? rd : rt;

    // Instruction decode and ALU; unknown opcodes/functs leave reg_write low (NOP).
    always_comb begin
        alu_res   = '0;
        reg_write = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                reg_write = 1'b1;
                case (funct)
                    6'h20:   alu_res = rfReadData_p0 + rfReadData_p1;
                    6'h22:   alu_res = rfReadData_p0 - rfReadData_p1;
                    6'h24:   alu_res = rfReadData_p0 & rfReadData_p1;
                    6'h25:   alu_res = rfReadData_p0 | rfReadData_p1;
                    6'h26:   alu_res = rfReadData_p0 ^ rfReadData_p1;
                    6'h2A:   alu_res = {31'd0, $signed(rfReadData_p0) < $signed(rfReadData_p1)};
                    6'h00:   alu_res = rfReadData_p1 << shamt;
                    6'h02:   alu_res = rfReadData_p1 >> shamt;
                    6'h03:   alu_res = $unsigned($signed(rfReadData_p1) >>> shamt);
                    default: reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin
                alu_res   = rfReadData_p0 + imm_sext;
                reg_write = 1'b1;
            end
            OP_ANDI: begin
                alu_res   = rfReadData_p0 & imm_zext;
                reg_write = 1'b1;
            end
            OP_ORI: begin
                alu_res   = rfReadData_p0 | imm_zext;
                reg_write = 1'b1;
            end
            OP_LW: begin
                alu_res   = rfReadData_p0 + imm_sext;
                reg_write = 1'b1;
                is_load   = 1'b1;
            end
            OP_SW: begin
                alu_res   = rfReadData_p0 + imm_sext;
                is_store  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        alu_d   = alu_q;
        st_d    = st_q;
        npc_d   = npc_q;
        case (state_q)
            S_FETCH: begin
                ir_d    = iCacheReadData;
                state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                alu_d   = alu_res;
                st_d    = rfReadData_p1;
                npc_d   = pc_plus4;
`ifdef MIPS_CORE_BRANCH_EN
                case (op)
                    OP_BEQ: if (rfReadData_p0 == rfReadData_p1) npc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
                    OP_BNE: if (rfReadData_p0 != rfReadData_p1) npc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
                    OP_J:   npc_d = {pc_plus4[31:28], ir_q[25:0], 2'b00};
                    default: ;
                endcase
`endif
                state_d = S_MEM;
            end
            S_MEM: state_d = S_WB;
            S_WB: begin
                pc_d    = npc_q;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            alu_q   <= '0;
            st_q    <= '0;
            npc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            alu_q   <= alu_d;
            st_q    <= st_d;
            npc_q   <= npc_d;
        end
    end

    // Outputs decode from state; reset forces even the PC-driven fetch address to zero.
    always_comb begin
        iCacheReadAddr  = rst ? '0 : pc_q;
        rfReadAddr_p0   = '0;
        rfReadAddr_p1   = '0;
        rfReadEn_p0     = 1'b0;
        rfReadEn_p1     = 1'b0;
        dCacheAddr      = '0;
        dCacheWriteData = '0;
        dCacheReadEn    = 1'b0;
        dCacheWriteEn   = 1'b0;
        rfWriteAddr_p0  = '0;
        rfWriteData_p0  = '0;
        rfWriteEn_p0    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_DECODE, S_EXECUTE: begin
                    rfReadAddr_p0 = rs;
                    rfReadAddr_p1 = rt;
                    rfReadEn_p0   = 1'b1;
                    rfReadEn_p1   = 1'b1;
                end
                S_MEM: begin
                    if (is_load) begin
                        dCacheAddr   = alu_q;
                        dCacheReadEn = 1'b1;
                    end else if (is_store) begin
                        dCacheAddr      = alu_q;
                        dCacheWriteData = st_q;
                        dCacheWriteEn   = 1'b1;
                    end
                end
                S_WB: begin
                    if (reg_write && dest != 5'd0) begin
                        rfWriteEn_p0   = 1'b1;
                        rfWriteAddr_p0 = dest;
                        rfWriteData_p0 = is_load ? dCacheReadData : alu_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_core.sv
// Directed bench for mips_core: bench-owned regfile/icache/dcache models, scoreboards for RF writes and dcache accesses.
module tb_mips_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] iCacheReadData, iCacheReadAddr;
    logic [31:0] dCacheReadData, dCacheWriteData, dCacheAddr;
    logic        dCacheWriteEn, dCacheReadEn;
    logic [31:0] rfReadData_p0, rfReadData_p1, rfWriteData_p0;
    logic [4:0]  rfReadAddr_p0, rfReadAddr_p1, rfWriteAddr_p0;
    logic        rfReadEn_p0, rfReadEn_p1, rfWriteEn_p0;

    mips_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .iCacheReadData(iCacheReadData), .iCacheReadAddr(iCacheReadAddr),
        .dCacheReadData(dCacheReadData), .dCacheWriteData(dCacheWriteData),
        .dCacheAddr(dCacheAddr), .dCacheWriteEn(dCacheWriteEn), .dCacheReadEn(dCacheReadEn),
        .rfReadData_p0(rfReadData_p0), .rfReadAddr_p0(rfReadAddr_p0), .rfReadEn_p0(rfReadEn_p0),
        .rfReadData_p1(rfReadData_p1), .rfReadAddr_p1(rfReadAddr_p1), .rfReadEn_p1(rfReadEn_p1),
        .rfWriteData_p0(rfWriteData_p0), .rfWriteAddr_p0(rfWriteAddr_p0), .rfWriteEn_p0(rfWriteEn_p0)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [4:0] a; logic [31:0] d;} rfw_t;
    typedef struct packed {logic we; logic [31:0] a; logic [31:0] d;} dca_t;
    rfw_t exp_rf[$];
    dca_t exp_dc[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] exp_pc   = 32'h0;

    logic [31:0] imem [64];
    logic [31:0] rf   [32];
    logic [31:0] dmem_q = 32'hDEADBEEF;
    logic [31:0] dc_rdata_q = 32'h0;

    assign iCacheReadData = imem[iCacheReadAddr[7:2]];
    assign rfReadData_p0  = rf[rfReadAddr_p0];
    assign rfReadData_p1  = rf[rfReadAddr_p1];
    assign dCacheReadData = dc_rdata_q;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (rfWriteEn_p0 && rfWriteAddr_p0 != 5'd0) begin
            rf[rfWriteAddr_p0] <= rfWriteData_p0;
        end
        if (dCacheWriteEn) dmem_q <= dCacheWriteData;
        if (dCacheReadEn) dc_rdata_q <= dmem_q;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && rfWriteEn_p0 === 1'b1) begin
            rfw_t e;
            check("rf_wr_expected", 32'(rfWriteEn_p0), 32'(exp_rf.size() != 0));
            if (exp_rf.size() != 0) begin
                e = exp_rf.pop_front();
                check("rf_wr_addr", 32'(rfWriteAddr_p0), 32'(e.a));
                check("rf_wr_data", rfWriteData_p0, e.d);
            end
        end
        if (!rst && (dCacheReadEn === 1'b1 || dCacheWriteEn === 1'b1)) begin
            dca_t e;
            check("dc_re_we_excl", 32'(dCacheReadEn & dCacheWriteEn), 32'h0);
            check("dc_acc_expected", 32'(dCacheReadEn | dCacheWriteEn), 32'(exp_dc.size() != 0));
            if (exp_dc.size() != 0) begin
                e = exp_dc.pop_front();
                check("dc_we", 32'(dCacheWriteEn), 32'(e.we));
                check("dc_re", 32'(dCacheReadEn), 32'(!e.we));
                check("dc_addr", dCacheAddr, e.a);
                if (e.we) check("dc_wdata", dCacheWriteData, e.d);
            end
        end
    end

    task automatic push_rf(input logic [4:0] a, input logic [31:0] d);
        exp_rf.push_back('{a: a, d: d});
    endtask

    task automatic push_dc(input logic we, input logic [31:0] a, input logic [31:0] d);
        exp_dc.push_back('{we: we, a: a, d: d});
    endtask

    // Called at a negedge inside FETCH; returns at the negedge inside the following FETCH.
    task automatic step(input logic [31:0] instr, input logic [31:0] next_pc);
        imem[exp_pc[7:2]] = instr;
        #1;
        check("fetch_pc", iCacheReadAddr, exp_pc);
        repeat (5) @(negedge clk);
        exp_pc = next_pc;
    endtask

    task automatic run(input logic [31:0] instr);
        step(instr, exp_pc + 32'd4);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        imem[0] = 32'h200A0007;
        repeat (2) @(negedge clk);
        check("rst_icache_addr", iCacheReadAddr, 32'h0);
        check("rst_rf_we", 32'(rfWriteEn_p0), 32'h0);
        check("rst_rf_re0", 32'(rfReadEn_p0), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("dec_re0", 32'(rfReadEn_p0), 32'h1);
        check("dec_ra0", 32'(rfReadAddr_p0), 32'd0);
        check("dec_ra1", 32'(rfReadAddr_p1), 32'd10);
        @(negedge clk);
        check("exe_re1", 32'(rfReadEn_p1), 32'h1);
        rst = 1'b1;
        #1;
        check("abort_icache_addr", iCacheReadAddr, 32'h0);
        check("abort_rd_en", {30'd0, rfReadEn_p0, rfReadEn_p1}, 32'h0);
        check("abort_rd_addr", {22'd0, rfReadAddr_p0, rfReadAddr_p1}, 32'h0);
        check("abort_dc_en", {30'd0, dCacheReadEn, dCacheWriteEn}, 32'h0);
        check("abort_dc_addr", dCacheAddr, 32'h0);
        check("abort_dc_wdata", dCacheWriteData, 32'h0);
        check("abort_rf_wr", {26'd0, rfWriteEn_p0, rfWriteAddr_p0}, 32'h0);
        check("abort_rf_wdata", rfWriteData_p0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        push_rf(10, 32'd7);             run(32'h200A0007);
        push_rf(11, 32'd5);             run(32'h200B0005);
        push_rf(9, 32'd12);             run(32'h014B4820);
        push_rf(9, 32'd17);             run(32'h21290005);
        push_rf(9, 32'd5);              run(32'h014B4824);
        push_rf(9, 32'd7);              run(32'h014B4825);
        run(32'h20000005);
        push_rf(10, 32'h100);           run(32'h340A0100);
        push_dc(1'b0, 32'h104, 32'h0);
        push_rf(9, 32'hDEADBEEF);       run(32'h8D490004);
        push_rf(9, 32'h55);             run(32'h34090055);
        push_dc(1'b1, 32'h104, 32'h55); run(32'hAD490004);
        push_rf(10, 32'hFFFFFFF0);      run(32'h200AFFF0);
        push_rf(9, 32'hFFFFFFFE);       run(32'h000A48C3);
        push_rf(9, 32'hFFFFFFEB);       run(32'h014B4822);
        push_rf(9, 32'h1);              run(32'h014B482A);
        push_rf(9, 32'h0FFFFFFF);       run(32'h000A4902);
        push_rf(9, 32'd20);             run(32'h000B4880);
        push_rf(9, 32'hFFFFFFF5);       run(32'h014B4826);
        push_rf(9, 32'h0000FF00);       run(32'h3149FF00);
        run(32'hFC000000);
`ifdef MIPS_CORE_BRANCH_EN
        step(32'h10000002, exp_pc + 32'd12);
`else
        step(32'h10000002, exp_pc + 32'd4);
`endif
        push_rf(11, 32'd1);             run(32'h200B0001);
        check("fetch_pc_final", iCacheReadAddr, exp_pc);

        check("rf_queue_empty", 32'(exp_rf.size()), 32'h0);
        check("dc_queue_empty", 32'(exp_dc.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
